// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP slice operand/result pipeline blocks.
package dsp_pkg;

    localparam int DSP_WIDTH     = 18;
    localparam int DSP_MAX_DEPTH = 16;

    // Bits needed to encode every tap position 0..depth.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: a data register plus its valid bit, cleared by reset or flush.
import dsp_pkg::*;

module dsp_pipe_stage #(
    parameter int WIDTH = DSP_WIDTH
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_cen,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Reset and flush clear identically and both override the enable.
    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_cen) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dsp_pipe_chain.sv
// Chain of DEPTH pipeline stages with a runtime tap, giving 0..DEPTH cycles of latency
// on one DSP operand/result path.
import dsp_pkg::*;

module dsp_pipe_chain #(
    parameter  int WIDTH = DSP_WIDTH,
    parameter  int DEPTH = 4,
    localparam int SEL_W = sel_width(DEPTH),
    localparam int CNT_W = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] occ,
    output logic             sel_err
);

    localparam logic [SEL_W-1:0] MAX_TAP = SEL_W'(DEPTH);

    // Index 0 is the chain input itself, so tap 0 is a pure bypass.
    logic [WIDTH-1:0] w_data  [0:DEPTH];
    logic             w_valid [0:DEPTH];
    logic [SEL_W-1:0] w_tap;
    logic             w_sel_err;
    logic [CNT_W-1:0] w_occ;

    assign w_data[0]  = d;
    assign w_valid[0] = in_valid;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        dsp_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .i_rst   (rst),
            .i_flush (flush),
            .i_cen   (cen),
            .i_data  (w_data[k-1]),
            .i_valid (w_valid[k-1]),
            .o_data  (w_data[k]),
            .o_valid (w_valid[k])
        );
    end

    // Out-of-range selects clamp to the last stage rather than wrapping.
    always_comb begin
        w_sel_err = (sel > MAX_TAP);
        w_tap     = w_sel_err ? MAX_TAP : sel;
    end

    always_comb begin
        w_occ = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_occ = w_occ + CNT_W'(w_valid[k]);
        end
    end

    assign q       = w_data[w_tap];
    assign q_valid = w_valid[w_tap];
    assign occ     = w_occ;
    assign sel_err = w_sel_err;

endmodule

// File: doc/dsp_pipe_chain.md
Name: dsp_pipe_chain

Overview:
Parametrised successor to the single optional DSP pipeline register. It provides a chain of up to DEPTH register stages with a runtime-selectable tap, so latency on one operand path runs from 0 (combinational bypass) to DEPTH cycles. Each stage carries a valid bit alongside the data. The chain supports clock enable, a flush input, and an occupancy count. It sits on the DSP slice operand/result paths (A, B, C, D, M, P) wherever the latency must be tuned without re-synthesis.

Parameters:
WIDTH, 18, data width of every stage.
DEPTH, 4, number of physical register stages; legal range 1..16.
SEL_W, $clog2(DEPTH+1), width of the sel port; localparam, never overridden.
CNT_W, $clog2(DEPTH+1), width of the occ port; localparam.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
cen  input  1  clock enable for all stages; when low, the chain holds.
flush  input  1  synchronous clear of all stage data and valid bits.
in_valid  input  1  qualifies d.
d  input  WIDTH  data into stage 1.
sel  input  SEL_W  active latency / output tap, 0..DEPTH.
q  output  WIDTH  selected tap data.
q_valid  output  1  selected tap valid.
occ  output  CNT_W  number of set valid bits in stages 1..DEPTH.
sel_err  output  1  high while sel > DEPTH.

Behaviour:
- Storage: stage k, for k=1..DEPTH, holds data_k[WIDTH-1:0] and v_k.
- Stage 0 is a name for the chain input: data_0=d, v_0=in_valid.
- Update priority on the rising edge of clk: rst > flush > cen.
  - rst=1: every data_k=0 and v_k=0, regardless of cen or flush.
  - flush=1 (rst=0): same clear as rst, regardless of cen.
  - cen=1: data_k<=data_(k-1) and v_k<=v_(k-1) for all k, all stages shifting in the same cycle.
  - cen=0: all stages hold.
- Data always shifts when cen=1, even if in_valid=0. No bubble collapsing. Valid bits only mark the data.
- Output tap (combinational from sel):
  - sel=0: q=d, q_valid=in_valid, a pure bypass with zero latency.
  - 1<=sel<=DEPTH: q=data_sel, q_valid=v_sel.
  - sel>DEPTH: clamp to DEPTH and assert sel_err=1. Otherwise sel_err=0.
- Latency: with cen held high and sel=N, a sample presented at edge t appears on q after edge t+N-1 (visible in cycle t+N).
- Changing sel mid-stream moves the tap immediately and does not rearrange stored data. Samples can be skipped or repeated. This is legal and must not be corrected.
- occ is the combinational popcount of v_1..v_DEPTH and is independent of sel.
- Output values during and after reset:
  - q=0, q_valid=0, occ=0 whenever sel>=1.
  - With sel=0, q and q_valid follow d and in_valid, even during rst.
- Reset or flush asserted mid-stream discards all in-flight samples. The first sample accepted in the following cycle (cen=1) starts a fresh chain.
- rst and flush asserted together: identical result. Counted as a single clear.
- No X propagation from the stages: every stage register is covered by rst.

Decomposition:
- Shared package dsp_pkg:
  - the DSP default width constant (18);
  - the max-depth constant (16);
  - a function returning the clog2-based select width.
- Sub-module dsp_pipe_stage: one stage (data + valid) with rst/flush/cen priority built in.
- Top module:
  - generate loop of DEPTH dsp_pipe_stage instances;
  - tap mux with clamp;
  - popcount for occ.

Test Plan:
1. Reset: WIDTH=18, DEPTH=4, sel=3, cen=1, feed d=0x3FFFF with in_valid=1 for 5 cycles, then assert rst for 1 cycle -> next cycle q=0, q_valid=0, occ=0.
2. Latency sweep: cen=1, in_valid=1, d=1,2,3,... each cycle, sel=0..4 in turn -> q equals d from N cycles earlier (sel=0: q=d the same cycle; sel=4: d=5 presented at cycle 5 appears at cycle 9).
3. Clock enable: sel=2, push 0x00A then 0x00B, drop cen for 3 cycles -> q holds 0x00A and occ holds 2; raise cen -> 0x00B appears on the next cycle.
4. Flush priority: chain full (occ=4), flush=1 with cen=0 -> after the edge occ=0 and q_valid=0. Repeat with rst=1 and flush=1 together -> same result.
5. Valid gaps: in_valid pattern 1,0,1,1 with d=0x11,0x22,0x33,0x44, sel=4 -> q_valid sequence 1,0,1,1 four cycles later, q=0x22 carried with q_valid=0.
6. Clamp: DEPTH=4, sel=6 (SEL_W=3) -> sel_err=1 and q equals the data_4 output; sel back to 3 -> sel_err=0, and the tap moves the same cycle without disturbing the stored data.
